// File: rtl/sync_fifo_pkg.sv
// Shared constants and types for the parameterised synchronous FIFO.
package sync_fifo_pkg;

  localparam int unsigned DEF_FIFO_WIDTH = 16;
  localparam int unsigned DEF_FIFO_DEPTH = 8;
  localparam int unsigned DEF_FIFO_PTR   = 3;

  // Read-mode encodings for the FWFT parameter
  localparam int unsigned FWFT_OFF = 0;
  localparam int unsigned FWFT_ON  = 1;

  // Registered occupancy status flags
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bus of the synchronous FIFO.
interface sync_fifo_param_if
  import sync_fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int unsigned FIFO_PTR   = DEF_FIFO_PTR
);

  logic                  write_en;
  logic [FIFO_WIDTH-1:0] write_data;
  logic                  read_en;
  logic                  clr_err;
  logic [FIFO_WIDTH-1:0] read_data;
  logic                  read_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [FIFO_PTR:0]     data_avail;
  logic [FIFO_PTR:0]     room_avail;
  logic                  overflow;
  logic                  underflow;

  // Environment side: issues requests, observes status and data
  modport master (
    output write_en, write_data, read_en, clr_err,
    input  read_data, read_valid, full, empty, almost_full, almost_empty,
           data_avail, room_avail, overflow, underflow
  );

  // FIFO side
  modport slave (
    input  write_en, write_data, read_en, clr_err,
    output read_data, read_valid, full, empty, almost_full, almost_empty,
           data_avail, room_avail, overflow, underflow
  );

endinterface : sync_fifo_param_if

// File: rtl/fifo_regfile.sv
// FIFO storage array: synchronous write port, asynchronous read port, no reset.
module fifo_regfile #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR   = 3
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [PTR-1:0]   wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [PTR-1:0]   rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Store the accepted write word; contents survive reset by design
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule : fifo_regfile

// File: rtl/sync_fifo_param.sv
// Parameterised single-clock FIFO with standard or first-word-fall-through
// read mode, occupancy counts, threshold flags and sticky error flags.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned FIFO_PTR   = DEF_FIFO_PTR,
  parameter int unsigned FWFT       = FWFT_OFF,
  parameter int unsigned AFULL_TH   = FIFO_DEPTH - 1,
  parameter int unsigned AEMPTY_TH  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  sync_fifo_param_if.slave   bus
);

  localparam int unsigned CW = FIFO_PTR + 1;
  localparam logic [CW-1:0]       DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]       AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0]       AEMPTY_C = CW'(AEMPTY_TH);
  localparam logic [FIFO_PTR-1:0] LAST_PTR = FIFO_PTR'(FIFO_DEPTH - 1);

  logic [FIFO_PTR-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_PTR-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         room_q, room_d;
  fifo_flags_t           flags_q, flags_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [FIFO_WIDTH-1:0] rd_word;

  // Requests are qualified by the registered flags only
  assign wr_acc = bus.write_en & ~flags_q.full;
  assign rd_acc = bus.read_en & ~flags_q.empty;

  // Next-state pointers, occupancy, flags and sticky errors
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    room_d   = room_q;
    flags_d  = flags_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + FIFO_PTR'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + FIFO_PTR'(1);
    end

    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // Flags come from the next occupancy so they line up with data_avail
    flags_d.full         = (cnt_d == DEPTH_C);
    flags_d.empty        = (cnt_d == '0);
    flags_d.almost_full  = (cnt_d >= AFULL_C);
    flags_d.almost_empty = (cnt_d <= AEMPTY_C);
    room_d               = DEPTH_C - cnt_d;

    // A fresh error wins over a simultaneous clear
    ovf_d = (bus.write_en & flags_q.full)  | (ovf_q & ~bus.clr_err);
    unf_d = (bus.read_en  & flags_q.empty) | (unf_q & ~bus.clr_err);
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q              <= '0;
      rd_ptr_q              <= '0;
      cnt_q                 <= '0;
      room_q                <= DEPTH_C;
      flags_q.full          <= 1'b0;
      flags_q.empty         <= 1'b1;
      flags_q.almost_full   <= (AFULL_TH == 0);
      flags_q.almost_empty  <= 1'b1;
      ovf_q                 <= 1'b0;
      unf_q                 <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      room_q   <= room_d;
      flags_q  <= flags_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_regfile #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .PTR   (FIFO_PTR)
  ) u_regfile (
    .clk       (clk),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (bus.write_data),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_word)
  );

  if (FWFT == FWFT_ON) begin : g_fwft
    // Head word is visible whenever the FIFO holds data; zero while empty
    assign bus.read_data  = flags_q.empty ? '0 : rd_word;
    assign bus.read_valid = ~flags_q.empty;
  end else begin : g_std
    logic [FIFO_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q;

    // Capture the popped word; hold the last value otherwise
    always_comb begin
      rdata_d = rdata_q;
      if (rd_acc) begin
        rdata_d = rd_word;
      end
    end

    // Read data register with one-cycle valid pulse
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rdata_q  <= rdata_d;
        rvalid_q <= rd_acc;
      end
    end

    assign bus.read_data  = rdata_q;
    assign bus.read_valid = rvalid_q;
  end

  assign bus.full         = flags_q.full;
  assign bus.empty        = flags_q.empty;
  assign bus.almost_full  = flags_q.almost_full;
  assign bus.almost_empty = flags_q.almost_empty;
  assign bus.data_avail   = cnt_q;
  assign bus.room_avail   = room_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule : sync_fifo_param
